// File: rtl/rock_pkg.sv
// Shared types and helpers for the DSP cry-volume link.
package rock_pkg;

    typedef enum logic [1:0] {
        UIT,
        METEN,
        KLAAR
    } state_t;

    localparam logic [6:0] VOL_MAX = 7'd127;
    localparam int SAMPLE_W = 8;

    // -128 has no 8-bit positive twin, so it saturates.
    function automatic logic [6:0] absSat(
        input logic [SAMPLE_W-1:0] s
    );
        logic [SAMPLE_W-1:0] n;
        n = ~s + 8'd1;
        if (s == 8'h80)
            return VOL_MAX;
        else if (s[SAMPLE_W-1])
            return n[6:0];
        else
            return s[6:0];
    endfunction

    function automatic logic isClip(
        input logic [SAMPLE_W-1:0] s
    );
        return (s == 8'h7f) || (s == 8'h80);
    endfunction

endpackage

// File: rtl/dsp_zender_piek.sv
// Running peak magnitude and clip flag for one window.
module piekDetector
    import rock_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                take,
    input  logic                first,
    output logic [6:0]          peak,
    output logic                clipRun
);

    logic [6:0] mag;
    logic       hit;

    assign mag = absSat(sample);
    assign hit = isClip(sample);

    // first restarts the window: load the sample if taken, else clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            peak    <= '0;
            clipRun <= 1'b0;
        end else if (first) begin
            peak    <= take ? mag : 7'd0;
            clipRun <= take & hit;
        end else if (take) begin
            if (mag > peak)
                peak <= mag;
            clipRun <= clipRun | hit;
        end
    end

endmodule

// File: rtl/dsp_zender.sv
// Windowed peak-volume producer feeding the stress block.
module dsp_zender
    import rock_pkg::*;
#(
    parameter int WINDOW = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                sampleValid,
    output logic [7:0]          DSPuitgang,
    output logic                DSPready,
    output logic                clip
);

    localparam int CW = $clog2(WINDOW);
    localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          acc;
    logic          first;
    logic [6:0]    peak;
    logic          clipRun;
    logic [6:0]    mag;
    logic [6:0]    peakFin;
    logic          clipFin;

    assign acc   = enable & sampleValid;
    assign first = (state != METEN);
    assign mag   = absSat(sample);

    // the closing sample is folded in on the same edge it arrives
    assign peakFin = (mag > peak) ? mag : peak;
    assign clipFin = clipRun | isClip(sample);

    piekDetector u_piek (
        .clk     (clk),
        .reset   (reset),
        .sample  (sample),
        .take    (acc),
        .first   (first),
        .peak    (peak),
        .clipRun (clipRun)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= UIT;
            cnt        <= '0;
            DSPuitgang <= '0;
            DSPready   <= 1'b0;
            clip       <= 1'b0;
        end else begin
            DSPready <= 1'b0;
            unique case (state)
                UIT: begin
                    cnt <= (acc ? ONE : '0);
                    if (enable)
                        state <= METEN;
                end
                METEN: begin
                    if (!enable) begin
                        state <= UIT;
                        cnt   <= '0;
                    end else if (acc) begin
                        if (cnt == LAST) begin
                            DSPuitgang <= {1'b0, peakFin};
                            clip       <= clipFin;
                            DSPready   <= 1'b1;
                            cnt        <= '0;
                            state      <= KLAAR;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                end
                KLAAR: begin
                    if (!enable) begin
                        state <= UIT;
                        cnt   <= '0;
                    end else begin
                        state <= METEN;
                        cnt   <= (acc ? ONE : '0);
                    end
                end
                default: begin
                    state <= UIT;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_zender.sv
// Directed checks for dsp_zender with a 4-sample window.
module tb_dsp_zender;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] sample;
    logic       sampleValid;
    logic [7:0] DSPuitgang;
    logic       DSPready;
    logic       clip;

    int tests;
    int fails;
    int nStrobe;
    int base;

    dsp_zender #(.WINDOW(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .sample      (sample),
        .sampleValid (sampleValid),
        .DSPuitgang  (DSPuitgang),
        .DSPready    (DSPready),
        .clip        (clip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk)
        if (DSPready)
            nStrobe++;

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic feed(input logic [7:0] s, input logic v);
        sample      = s;
        sampleValid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        enable      = 1'b0;
        sampleValid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expStrobe(input string tag, input int val, input int cl);
        chk({tag, ".rdy"}, DSPready, 1);
        chk({tag, ".val"}, DSPuitgang, val);
        chk({tag, ".clip"}, clip, cl);
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        nStrobe = 0;
        reset   = 1'b0;
        enable  = 1'b0;
        sample  = 8'd0;
        sampleValid = 1'b0;

        // reset held with random inputs
        for (int i = 0; i < 6; i++) begin
            enable      = 1'($urandom);
            sampleValid = 1'($urandom);
            sample      = 8'($urandom);
            @(posedge clk);
            #1;
        end
        chk("rst.val", DSPuitgang, 0);
        chk("rst.clip", clip, 0);
        chk("rst.rdy", DSPready, 0);
        chk("rst.strobes", nStrobe, 0);

        enable = 1'b0;
        sampleValid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(4);
        chk("rel.val", DSPuitgang, 0);
        chk("rel.strobes", nStrobe, 0);

        // basic window
        base = nStrobe;
        enable = 1'b1;
        feed(8'd10, 1);
        feed(-8'sd50, 1);
        feed(8'd30, 1);
        chk("basic.early", nStrobe - base, 0);
        feed(8'd5, 1);
        expStrobe("basic", 50, 0);
        feed(8'd0, 0);
        chk("basic.pulse", DSPready, 0);
        chk("basic.count", nStrobe - base, 1);

        // saturation, then a back-to-back window
        idle(2);
        enable = 1'b1;
        feed(8'h80, 1);
        feed(8'd0, 1);
        feed(8'd0, 1);
        feed(8'd0, 1);
        expStrobe("sat", 127, 1);
        feed(8'd1, 1);
        feed(8'd2, 1);
        feed(8'd3, 1);
        feed(8'd4, 1);
        expStrobe("sat2", 4, 0);

        // boundary: sample taken in the strobe cycle belongs to next window
        idle(2);
        base = nStrobe;
        enable = 1'b1;
        repeat (4) feed(8'd20, 1);
        expStrobe("bnd1", 20, 0);
        repeat (3) feed(8'd90, 1);
        chk("bnd.mid", DSPready, 0);
        feed(8'd90, 1);
        expStrobe("bnd2", 90, 0);
        chk("bnd.count", nStrobe - base, 1);

        // gapped valid
        idle(2);
        base = nStrobe;
        enable = 1'b1;
        feed(8'd7, 1);
        feed(8'd99, 0);
        feed(8'd7, 1);
        feed(8'd99, 0);
        feed(8'd7, 1);
        feed(8'd99, 0);
        chk("gap.early", nStrobe - base, 0);
        feed(8'd7, 1);
        expStrobe("gap", 7, 0);

        // abort by enable
        idle(2);
        base = nStrobe;
        enable = 1'b1;
        feed(8'd60, 1);
        feed(8'd10, 1);
        idle(3);
        chk("abrt.none", nStrobe - base, 0);
        enable = 1'b1;
        repeat (4) feed(8'd1, 1);
        expStrobe("abrt", 1, 0);

        // abort by reset
        idle(2);
        base = nStrobe;
        enable = 1'b1;
        feed(8'd60, 1);
        feed(8'd10, 1);
        reset = 1'b0;
        #1;
        chk("rabrt.val0", DSPuitgang, 0);
        sampleValid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk("rabrt.none", nStrobe - base, 0);
        repeat (4) feed(8'd1, 1);
        expStrobe("rabrt", 1, 0);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got 0, expected 1");
        $fatal(1);
    end

endmodule
